// File: rtl/seq_popcount_engine.sv
// Sequential population counter: latches a WIDTH-bit vector and counts CHUNK bits per clock,
// optionally counting zeros and accumulating (with saturation) across successive vectors.
module seq_popcount_engine #(
    parameter int WIDTH = 127,
    parameter int CHUNK = 16,
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    input  logic             count_zeros,
    input  logic             accum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] count_out,
    output logic             saturated
);

    localparam int NCH = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PW  = NCH * CHUNK;
    localparam int KW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int CW  = $clog2(CHUNK + 1);
    localparam logic [KW-1:0]    LAST_IDX = KW'(NCH - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        DONE
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] vec_in;
    logic [PW-1:0]    vec;
    logic [KW-1:0]    idx;
    logic [ACC_W-1:0] acc;
    logic             sat;
    logic             accept;
    logic             last_chunk;
    logic [CHUNK-1:0] chunk;
    logic [CW-1:0]    chunk_pop;
    logic [ACC_W:0]   sum;

    assign in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign last_chunk = (idx == LAST_IDX);
    assign out_valid  = (state == DONE);
    assign count_out  = acc;
    assign saturated  = sat;

    // Invert before widening so the padding chunk bits stay zero in zero-count mode.
    assign vec_in = count_zeros ? ~data_in : data_in;
    assign chunk  = vec[int'(idx) * CHUNK +: CHUNK];

    always_comb begin
        chunk_pop = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_pop = chunk_pop + CW'(chunk[i]);
        end
    end

    assign sum = {1'b0, acc} + (ACC_W + 1)'(chunk_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = COUNT;
            COUNT:   if (last_chunk) state_next = DONE;
            DONE: begin
                if (accept) begin
                    state_next = COUNT;
                end else if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // An accept in accumulate mode keeps the previous result and its sticky flag as the start value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec <= '0;
            idx <= '0;
            acc <= '0;
            sat <= 1'b0;
        end else if (accept) begin
            vec <= PW'(vec_in);
            idx <= '0;
            if (!accum) begin
                acc <= '0;
                sat <= 1'b0;
            end
        end else if (state == COUNT) begin
            if (sum[ACC_W]) begin
                acc <= ACC_MAX;
                sat <= 1'b1;
            end else begin
                acc <= sum[ACC_W-1:0];
            end
            if (!last_chunk) begin
                idx <= idx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_popcount_engine.sv
// Bench for seq_popcount_engine: four configurations share one stimulus stream and are each
// compared every cycle against a transaction-level model built on $countones.
module tb_seq_popcount_engine;

    localparam int W = 127;
    localparam int NI = 4;
    localparam int CH_P [NI] = '{16, 16, 127, 5};
    localparam int AW_P [NI] = '{16, 7, 16, 16};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  data_in;
    logic          count_zeros;
    logic          accum;
    logic          out_ready;
    logic [NI-1:0] rdy;
    logic [NI-1:0] ov;
    logic [NI-1:0] sat;
    logic [15:0]   cnt [NI];

    int checks = 0;
    int errors = 0;
    int lat [NI];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [AW_P[g]-1:0] co;
        seq_popcount_engine #(.WIDTH(W), .CHUNK(CH_P[g]), .ACC_W(AW_P[g])) dut (
            .clk(clk),
            .rst_n(rst_n),
            .in_valid(in_valid),
            .in_ready(rdy[g]),
            .data_in(data_in),
            .count_zeros(count_zeros),
            .accum(accum),
            .out_valid(ov[g]),
            .out_ready(out_ready),
            .count_out(co),
            .saturated(sat[g])
        );
        assign cnt[g] = 16'(co);
    end

    // Model: result decided at accept with $countones, visible after NCH edges, held until consumed.
    int m_res  [NI];
    bit m_sat  [NI];
    int m_left [NI];
    bit m_pend [NI];

    function automatic int nch(int i);
        return (W + CH_P[i] - 1) / CH_P[i];
    endfunction

    function automatic int maxv(int i);
        return (1 << AW_P[i]) - 1;
    endfunction

    function automatic int vec_count();
        return count_zeros ? W - $countones(data_in) : $countones(data_in);
    endfunction

    function automatic int new_total(int i);
        return (accum ? m_res[i] : 0) + vec_count();
    endfunction

    function automatic bit exp_valid(int i);
        return m_pend[i] && (m_left[i] == 0);
    endfunction

    function automatic bit exp_ready(int i);
        return !m_pend[i] || (m_left[i] == 0 && out_ready);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NI; i++) begin
                m_res[i]  <= 0;
                m_sat[i]  <= 1'b0;
                m_left[i] <= 0;
                m_pend[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (in_valid && exp_ready(i)) begin
                    m_res[i]  <= (new_total(i) > maxv(i)) ? maxv(i) : new_total(i);
                    m_sat[i]  <= (accum && m_sat[i]) || (new_total(i) > maxv(i));
                    m_left[i] <= nch(i);
                    m_pend[i] <= 1'b1;
                end else if (m_pend[i] && m_left[i] > 0) begin
                    m_left[i] <= m_left[i] - 1;
                end else if (m_pend[i] && out_ready) begin
                    m_pend[i] <= 1'b0;
                end
            end
        end
    end

    task automatic checkOutput(input string name, input int actual, input int required);
        checks++;
        if (actual !== required) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, required, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < NI; i++) begin
                checkOutput($sformatf("in_ready[%0d]", i), int'(rdy[i]), int'(exp_ready(i)));
                checkOutput($sformatf("out_valid[%0d]", i), int'(ov[i]), int'(exp_valid(i)));
                if (exp_valid(i)) begin
                    checkOutput($sformatf("count_out[%0d]", i), int'(cnt[i]), m_res[i]);
                    checkOutput($sformatf("saturated[%0d]", i), int'(sat[i]), int'(m_sat[i]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitValid();
        int edges;
        bit done;
        edges = 0;
        done = 1'b0;
        for (int i = 0; i < NI; i++) lat[i] = -1;
        for (int c = 0; c < 40 && !done; c++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (ov[i] && lat[i] < 0) lat[i] = edges;
            end
            done = &ov;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_out_valid actual=%b required=1111", ov);
        end
    endtask

    // Precondition: every instance idle, so all of them accept on the same edge.
    task automatic applyStimulus(input logic [W-1:0] d, input logic cz, input logic ac);
        tick();
        in_valid = 1'b1;
        data_in = d;
        count_zeros = cz;
        accum = ac;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        waitValid();
    endtask

    task automatic drain();
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    logic [W-1:0] ones_v;
    logic [W-1:0] alt_v;
    logic [127:0] rnd;

    initial begin
        ones_v = '1;
        alt_v = '0;
        for (int b = 0; b < W; b += 2) alt_v[b] = 1'b1;
        in_valid = 1'b0;
        data_in = '0;
        count_zeros = 1'b0;
        accum = 1'b0;
        out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checkOutput($sformatf("reset_in_ready[%0d]", i), int'(rdy[i]), 1);
            checkOutput($sformatf("reset_out_valid[%0d]", i), int'(ov[i]), 0);
            checkOutput($sformatf("reset_count[%0d]", i), int'(cnt[i]), 0);
            checkOutput($sformatf("reset_sat[%0d]", i), int'(sat[i]), 0);
        end
        repeat (3) tick();
        rst_n = 1'b1;

        applyStimulus(ones_v, 1'b0, 1'b0);
        checkOutput("t1_latency_chunk16", lat[0], 8);
        checkOutput("t1_latency_chunk127", lat[2], 1);
        checkOutput("t1_latency_chunk5", lat[3], 26);
        checkOutput("t1_count", int'(cnt[0]), 127);
        checkOutput("t1_sat", int'(sat[0]), 0);
        checkOutput("t1_count_accw7", int'(cnt[1]), 127);
        checkOutput("t1_sat_accw7", int'(sat[1]), 0);
        drain();

        applyStimulus('0, 1'b1, 1'b0);
        checkOutput("t2_zero_count", int'(cnt[0]), 127);
        checkOutput("t2_zero_count_chunk5", int'(cnt[3]), 127);
        drain();

        applyStimulus(alt_v, 1'b0, 1'b0);
        checkOutput("t3_alt_count", int'(cnt[0]), 64);
        for (int c = 0; c < 5; c++) begin
            tick();
            checkOutput("t3_hold_count", int'(cnt[0]), 64);
            checkOutput("t3_hold_in_ready", int'(rdy[0]), 0);
            checkOutput("t3_hold_out_valid", int'(ov[0]), 1);
        end
        tick();
        out_ready = 1'b1;
        in_valid = 1'b1;
        data_in = 127'h1;
        count_zeros = 1'b0;
        accum = 1'b1;
        #1;
        checkOutput("t3_bubble_in_ready", int'(rdy[0]), 1);
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        waitValid();
        checkOutput("t3_accum_count", int'(cnt[0]), 65);
        drain();

        applyStimulus(ones_v, 1'b0, 1'b0);
        drain();
        applyStimulus(ones_v, 1'b0, 1'b1);
        checkOutput("t4_sat_count_accw7", int'(cnt[1]), 127);
        checkOutput("t4_sat_flag_accw7", int'(sat[1]), 1);
        checkOutput("t4_count_accw16", int'(cnt[0]), 254);
        checkOutput("t4_sat_flag_accw16", int'(sat[0]), 0);
        drain();
        applyStimulus(127'h100, 1'b0, 1'b0);
        checkOutput("t4_fresh_count_accw7", int'(cnt[1]), 1);
        checkOutput("t4_fresh_sat_accw7", int'(sat[1]), 0);
        drain();

        tick();
        in_valid = 1'b1;
        data_in = ones_v;
        accum = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        checkOutput("t5_reset_count", int'(cnt[0]), 0);
        checkOutput("t5_reset_out_valid_chunk127", int'(ov[2]), 0);
        checkOutput("t5_reset_count_chunk127", int'(cnt[2]), 0);
        checkOutput("t5_reset_in_ready", int'(rdy[0]), 1);
        repeat (2) tick();
        rst_n = 1'b1;
        applyStimulus(127'h7, 1'b0, 1'b1);
        checkOutput("t5_after_reset_count", int'(cnt[0]), 3);
        checkOutput("t5_after_reset_count_chunk5", int'(cnt[3]), 3);
        drain();

        for (int c = 0; c < 8000; c++) begin
            tick();
            rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
            case ($urandom_range(0, 7))
                0: data_in = '1;
                1: data_in = '0;
                default: data_in = rnd[W-1:0];
            endcase
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            count_zeros = $urandom_range(0, 1) != 0;
            accum = $urandom_range(0, 1) != 0;
        end
        tick();
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
